chnnl_queue: RTL

CHNNL_QUEUE -- requirements
Module: chnnl_queue

---
 rtl/eq_pkg.sv | 16 +
 rtl/chnnl_queue_dualport_ram.sv | 46 ++++
 rtl/chnnl_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: constants and types shared by the channel queue and its RAM.
//   SMPL_W        - width of one audio sample (per channel)
//   RAM_W         - width of one RAM word, {left, right}
//   queue_state_t - queue FSM states: FILL, FULL, READ
package eq_pkg;

    localparam int SMPL_W = 24;
    localparam int RAM_W  = 2 * SMPL_W;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        READ = 2'd2
    } queue_state_t;

endpackage : eq_pkg

// File: rtl/chnnl_queue_dualport_ram.sv
// dualport_ram: simple dual-port RAM, one synchronous write port and one
// synchronous read port with a registered (1-cycle) output.
//   clk   - clock
//   rst_n - async active-low reset, clears only the read data register
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   re    - read enable; rdata holds its value while re is low
//   raddr - read address
//   rdata - registered read data
// The array itself is never reset. Callers never read and write the same
// address in the same cycle, so no collision behaviour is defined.
module dualport_ram #(
    parameter int DEPTH = 1024,
    parameter int W     = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : dualport_ram

// File: rtl/chnnl_queue.sv
// chnnl_queue: sliding-window sample queue between the I2S deserializer and
// the FIR stage. Keeps the most recent READ_LEN stereo samples; every new
// sample (once full) discards the oldest and replays the whole window,
// oldest to newest, one sample per cycle.
//   clk, rst_n          - clock, async active-low reset
//   lft_smpl, rght_smpl - incoming stereo sample
//   wrt_smpl            - one-cycle strobe, samples valid
//   lft_out, rght_out   - replayed sample, held while sequencing is low
//   sequencing          - high exactly on cycles carrying replay data
//   ovr                 - sticky overrun flag
// Handshake: wrt_smpl has no ready; a strobe arriving while a replay is in
// progress (READ state, including its last address cycle) is dropped.
// Build option: define CHNNL_QUEUE_OVR_EN to make ovr record dropped
// strobes (cleared only by reset); otherwise ovr is tied low.
module chnnl_queue
    import eq_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int READ_LEN = 1021
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SMPL_W-1:0] lft_smpl,
    input  logic [SMPL_W-1:0] rght_smpl,
    input  logic              wrt_smpl,
    output logic [SMPL_W-1:0] lft_out,
    output logic [SMPL_W-1:0] rght_out,
    output logic              sequencing,
    output logic              ovr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] READ_LEN_C = AW'(READ_LEN);
    localparam logic [AW-1:0] LAST_RD_C  = AW'(READ_LEN - 1);

    queue_state_t  state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] optr_q, optr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          sequencing_q, sequencing_d;
    logic          ram_we, ram_re;
    logic [RAM_W-1:0] ram_rdata;
`ifdef CHNNL_QUEUE_OVR_EN
    logic          ovr_q, ovr_d;
`endif

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        optr_d   = optr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        rd_cnt_d = rd_cnt_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
`ifdef CHNNL_QUEUE_OVR_EN
        ovr_d    = ovr_q;
`endif
        case (state_q)
            FILL: begin
                if (wrt_smpl) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_d == READ_LEN_C) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (wrt_smpl) begin
                    ram_we   = 1'b1;
                    wptr_d   = wptr_q + 1'b1;
                    optr_d   = optr_q + 1'b1;
                    // Replay starts at the new oldest entry.
                    rptr_d   = optr_q + 1'b1;
                    rd_cnt_d = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                ram_re   = 1'b1;
                rptr_d   = rptr_q + 1'b1;
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_RD_C) begin
                    state_d = FULL;
                end
`ifdef CHNNL_QUEUE_OVR_EN
                if (wrt_smpl) begin
                    ovr_d = 1'b1;
                end
`endif
            end
            default: state_d = FILL;
        endcase
        // Read data appears one cycle after each READ address cycle.
        sequencing_d = (state_q == READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wptr_q       <= '0;
            optr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            sequencing_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            optr_q       <= optr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            sequencing_q <= sequencing_d;
        end
    end

`ifdef CHNNL_QUEUE_OVR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end
    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    dualport_ram #(
        .DEPTH (DEPTH),
        .W     (RAM_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata ({lft_smpl, rght_smpl}),
        .re    (ram_re),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    assign lft_out    = ram_rdata[RAM_W-1:SMPL_W];
    assign rght_out   = ram_rdata[SMPL_W-1:0];
    assign sequencing = sequencing_q;

endmodule : chnnl_queue
